// File: rtl/coin_sense_front_if.sv
// coin_sense_front_if
//   Bundles the raw coin-slot sensor lines and the cleaned coin/reject
//   outputs of the coin sensing front end.
//   nickel_raw : raw 5c sensor, 1 = coin present
//   dime_raw   : raw 10c sensor, 1 = coin present
//   coin       : one-cycle coin code (01 = 5c, 10 = 10c, 00 = idle)
//   reject     : one-cycle pulse, coin dropped because the queue was full
//   master : the side that owns the sensors and consumes coin/reject
//   slave  : the coin_sense_front block
interface coin_sense_front_if;
    logic       nickel_raw;
    logic       dime_raw;
    logic [1:0] coin;
    logic       reject;

    modport master (output nickel_raw, output dime_raw, input coin, input reject);
    modport slave  (input nickel_raw, input dime_raw, output coin, output reject);
endinterface

// File: rtl/coin_sense_front.sv
// coin_sense_front
//   Turns two bouncy coin-slot sensors into clean one-cycle coin codes for
//   the vending FSM: 2-flop synchroniser, per-channel debounce, rising-edge
//   event, 2-entry coin queue, and an output stage that always leaves at
//   least one idle cycle between coin pulses.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : coin_sense_front_if.slave (nickel_raw, dime_raw in; coin, reject out)
module coin_sense_front #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                clock,
    input  logic                reset,
    coin_sense_front_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CODE_NICKEL = 2'b01;
    localparam logic [1:0] CODE_DIME   = 2'b10;

    // Channel index: bit 0 = nickel, bit 1 = dime.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       stable;
    logic [1:0]       rise;
    logic [CNT_W-1:0] cnt [2];

    // Synchroniser, debounce and edge flag.
    // Stable levels reset to 1 so a sensor held high through reset is not
    // mistaken for a fresh coin.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '1;
            rise   <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1 <= {bus.dime_raw, bus.nickel_raw};
            sync2 <= sync1;
            rise  <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                    // Only a 0->1 flip of the accepted level is a coin.
                    rise[i]   <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Coin queue: 2 entries, 1-bit pointers plus an occupancy count.
    logic [1:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       gap;

    logic       pop;
    logic [1:0] count_after_pop;
    logic [1:0] count_mid;
    logic       acc_dime;
    logic       acc_nickel;
    logic       drop;

    // The pop is taken first so a full queue can accept a push on the same
    // edge; the dime is then offered before the nickel.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        pop             = 1'b0;
        count_after_pop = count;
        acc_dime        = 1'b0;
        acc_nickel      = 1'b0;
        count_mid       = count;
        drop            = 1'b0;

        pop             = !gap && (count != 2'd0);
        count_after_pop = count - {1'b0, pop};
        acc_dime        = rise[1] && (count_after_pop != 2'd2);
        count_mid       = count_after_pop + {1'b0, acc_dime};
        acc_nickel      = rise[0] && (count_mid != 2'd2);
        drop            = (rise[1] && !acc_dime) || (rise[0] && !acc_nickel);
    end

    // NOTE: queue storage carries no reset; the occupancy count guards every
    // read, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (acc_dime)   mem[wr_ptr] <= CODE_DIME;
        if (acc_nickel) mem[wr_ptr ^ acc_dime] <= CODE_NICKEL;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            gap        <= 1'b0;
            bus.coin   <= 2'b00;
            bus.reject <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr ^ acc_dime ^ acc_nickel;
            count      <= count_mid + {1'b0, acc_nickel};
            bus.reject <= drop;
            // A delivered coin is always followed by an idle cycle, which
            // covers the vending FSM's dispense cycle.
            if (pop) begin
                bus.coin <= mem[rd_ptr];
                rd_ptr   <= ~rd_ptr;
                gap      <= 1'b1;
            end else begin
                bus.coin <= 2'b00;
                gap      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_coin_sense_front.sv
// tb_coin_sense_front
//   Directed bench for coin_sense_front. One instance uses the default
//   4-cycle debounce; a second uses a 1-cycle debounce so coins can arrive
//   fast enough to overflow the queue.
module tb_coin_sense_front;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    coin_sense_front_if if4 ();
    coin_sense_front_if if1 ();

    coin_sense_front #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (if4.slave)
    );

    coin_sense_front #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Step past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle4(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            tick();
            check($sformatf("%s coin c%0d", tag, k), if4.coin, 2'b00);
            check($sformatf("%s reject c%0d", tag, k), {1'b0, if4.reject}, 2'b00);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        if4.nickel_raw = 1'b0;
        if4.dime_raw   = 1'b0;
        if1.nickel_raw = 1'b0;
        if1.dime_raw   = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("reset coin4", if4.coin, 2'b00);
        check("reset reject4", {1'b0, if4.reject}, 2'b00);
        check("reset coin1", if1.coin, 2'b00);
        check("reset reject1", {1'b0, if1.reject}, 2'b00);
        reset = 1'b1;
        idle4("post-reset", 8);

        // Nickel held 10 cycles: one 01 pulse after edge 3+4 = 7.
        for (int j = 0; j < 12; j++) begin
            if4.nickel_raw = (j < 10);
            tick();
            check($sformatf("nickel coin e%0d", j), if4.coin, (j == 7) ? 2'b01 : 2'b00);
            check($sformatf("nickel reject e%0d", j), {1'b0, if4.reject}, 2'b00);
        end
        idle4("nickel fall", 8);

        // Dime glitch of 3 cycles is absorbed.
        for (int j = 0; j < 12; j++) begin
            if4.dime_raw = (j < 3);
            tick();
            check($sformatf("glitch coin e%0d", j), if4.coin, 2'b00);
        end
        // Dime held 6 cycles: one 10 pulse after edge 7.
        for (int j = 0; j < 12; j++) begin
            if4.dime_raw = (j < 6);
            tick();
            check($sformatf("dime coin e%0d", j), if4.coin, (j == 7) ? 2'b10 : 2'b00);
        end
        idle4("dime fall", 8);

        // Both rise together: dime first, one idle cycle, then nickel.
        for (int j = 0; j < 12; j++) begin
            if4.nickel_raw = (j < 6);
            if4.dime_raw   = (j < 6);
            tick();
            check($sformatf("both coin e%0d", j), if4.coin,
                  (j == 7) ? 2'b10 : (j == 9) ? 2'b01 : 2'b00);
            check($sformatf("both reject e%0d", j), {1'b0, if4.reject}, 2'b00);
        end
        idle4("both fall", 8);

        // Overflow on the 1-cycle debounce instance: both channels pulse at
        // sampled edges 0 and 2. The first pair fills the queue; of the
        // second pair only the dime fits, the nickel is rejected.
        for (int j = 0; j < 12; j++) begin
            if1.nickel_raw = (j == 0) || (j == 2);
            if1.dime_raw   = (j == 0) || (j == 2);
            tick();
            check($sformatf("ovf coin e%0d", j), if1.coin,
                  (j == 4 || j == 8) ? 2'b10 : (j == 6) ? 2'b01 : 2'b00);
            check($sformatf("ovf reject e%0d", j), {1'b0, if1.reject},
                  (j == 5) ? 2'b01 : 2'b00);
        end

        // Nickel held high across reset release produces no coin.
        if4.nickel_raw = 1'b1;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        idle4("held through reset", 10);
        if4.nickel_raw = 1'b0;
        idle4("held lowered", 8);
        for (int j = 0; j < 12; j++) begin
            if4.nickel_raw = 1'b1;
            tick();
            check($sformatf("re-raise coin e%0d", j), if4.coin, (j == 7) ? 2'b01 : 2'b00);
        end
        if4.nickel_raw = 1'b0;
        idle4("re-raise fall", 8);

        // Asynchronous reset while dime is on the bus and nickel is queued.
        for (int j = 0; j < 8; j++) begin
            if4.nickel_raw = 1'b1;
            if4.dime_raw   = 1'b1;
            tick();
            check($sformatf("pre-abort coin e%0d", j), if4.coin, (j == 7) ? 2'b10 : 2'b00);
        end
        #2;
        reset = 1'b0;
        if4.nickel_raw = 1'b0;
        if4.dime_raw   = 1'b0;
        #1;
        check("abort coin", if4.coin, 2'b00);
        check("abort reject", {1'b0, if4.reject}, 2'b00);
        tick();
        reset = 1'b1;
        idle4("after abort", 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
